forward_dispatcher: RTL and testbench

FORWARD_DISPATCHER -- requirements
Module: forward_dispatcher

---
 rtl/forward_dispatcher_pkg.sv | 43 ++++
 rtl/forward_dispatcher_if.sv | 24 ++
 rtl/forward_dispatcher_port_mask_gen.sv | 28 ++
 rtl/forward_dispatcher.sv | 217 +++++++++++++++++++++
 tb/tb_forward_dispatcher.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_dispatcher_pkg.sv
// Shared definitions for the forward dispatcher.
// mem_pkg carries the buffer-memory geometry; fwd_pkg carries the FSM
// state enum, forwarding class, port mask type and width helpers.
package mem_pkg;
    localparam int unsigned ADDR_W = 12;
endpackage

package fwd_pkg;
    localparam int unsigned ADDR_W    = mem_pkg::ADDR_W;
    localparam int unsigned MAX_PORTS = 16;

    typedef logic [MAX_PORTS-1:0] port_mask_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOOKUP   = 2'd1,
        S_DISPATCH = 2'd2
    } fwd_state_e;

    // How a frame is forwarded once its destination is resolved.
    typedef enum logic [1:0] {
        CLS_FLOOD   = 2'd0,
        CLS_UNICAST = 2'd1,
        CLS_SELF    = 2'd2
    } fwd_class_e;

    function automatic int unsigned port_w(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [4:0] popcount(input port_mask_t m);
        logic [4:0] c;
        c = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            c = c + 5'(m[i]);
        end
        return c;
    endfunction
endpackage

// File: rtl/forward_dispatcher_if.sv
// Frame descriptor handshake between the ingress side and the dispatcher.
interface forward_dispatcher_if #(
    parameter int unsigned NUM_PORTS = 4
);
    import fwd_pkg::*;
    localparam int unsigned PORT_W = port_w(NUM_PORTS);

    logic              in_valid_i;
    logic              in_ready_o;
    logic [ADDR_W-1:0] start_ptr_i;
    logic [47:0]       dest_addr_i;
    logic [47:0]       src_addr_i;
    logic [PORT_W-1:0] src_port_i;

    modport master (
        output in_valid_i, start_ptr_i, dest_addr_i, src_addr_i, src_port_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i, start_ptr_i, dest_addr_i, src_addr_i, src_port_i,
        output in_ready_o
    );
endinterface

// File: rtl/forward_dispatcher_port_mask_gen.sv
// Egress port mask and its population count for a given forwarding class.
module port_mask_gen
    import fwd_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 4,
    localparam int unsigned PORT_W    = port_w(NUM_PORTS),
    localparam int unsigned CNT_W     = cnt_w(NUM_PORTS)
) (
    input  fwd_class_e           cls_i,
    input  logic [PORT_W-1:0]    hit_port_i,
    input  logic [PORT_W-1:0]    src_port_i,
    output logic [NUM_PORTS-1:0] mask_o,
    output logic [CNT_W-1:0]     count_o
);
    // Flood excludes the ingress port; a self hit forwards nowhere.
    always_comb begin
        mask_o = '0;
        case (cls_i)
            CLS_FLOOD: begin
                mask_o             = '1;
                mask_o[src_port_i] = 1'b0;
            end
            CLS_UNICAST: mask_o[hit_port_i] = 1'b1;
            default:     mask_o = '0;
        endcase
        count_o = CNT_W'(popcount(port_mask_t'(mask_o)));
    end
endmodule

// File: rtl/forward_dispatcher.sv
// Forward dispatcher: resolves a frame's egress ports (group flood, table
// lookup with timeout, self-hit drop) and enqueues it on each egress port.
// Optional statistics counters are enabled with the FWD_STATS_EN macro.
module forward_dispatcher
    import fwd_pkg::*;
#(
    parameter  int unsigned NUM_PORTS      = 4,
    parameter  int unsigned LOOKUP_TIMEOUT = 15,
    localparam int unsigned PORT_W         = port_w(NUM_PORTS),
    localparam int unsigned CNT_W          = cnt_w(NUM_PORTS)
) (
    input  logic                              clk,
    input  logic                              rst,
    forward_dispatcher_if.slave               in_if,
    output logic                              lookup_req_o,
    output logic [47:0]                       lookup_addr_o,
    input  logic                              lookup_valid_i,
    input  logic                              lookup_hit_i,
    input  logic [PORT_W-1:0]                 lookup_port_i,
    output logic                              learn_en_o,
    output logic [47:0]                       learn_addr_o,
    output logic [PORT_W-1:0]                 learn_port_o,
    output logic [NUM_PORTS-1:0]              write_reqs_o,
    input  logic [NUM_PORTS-1:0]              write_acks_i,
    output logic [NUM_PORTS-1:0][ADDR_W-1:0]  start_ptrs_o,
    output logic [CNT_W-1:0]                  refcount_o,
    output logic                              refcount_valid_o,
`ifdef FWD_STATS_EN
    output logic [31:0]                       stat_unicast_o,
    output logic [31:0]                       stat_flood_o,
    output logic [31:0]                       stat_drop_o,
`endif
    output logic                              drop_o
);
    localparam int unsigned TMO_W = $clog2(LOOKUP_TIMEOUT + 1);

    fwd_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [47:0]           dest_q, dest_d;
    logic [47:0]           src_q, src_d;
    logic [PORT_W-1:0]     sport_q, sport_d;
    logic [TMO_W-1:0]      timer_q, timer_d;
    logic [NUM_PORTS-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  learn_q, learn_d;
    logic                  rcv_q, rcv_d;
    logic                  drop_q, drop_d;
`ifdef FWD_STATS_EN
    logic [31:0]           st_uni_q, st_uni_d;
    logic [31:0]           st_fld_q, st_fld_d;
    logic [31:0]           st_drp_q, st_drp_d;
`endif

    fwd_class_e            mg_cls;
    logic [PORT_W-1:0]     mg_sport;
    logic [NUM_PORTS-1:0]  mg_mask;
    logic [CNT_W-1:0]      mg_count;

    port_mask_gen #(.NUM_PORTS(NUM_PORTS)) u_mask (
        .cls_i      (mg_cls),
        .hit_port_i (lookup_port_i),
        .src_port_i (mg_sport),
        .mask_o     (mg_mask),
        .count_o    (mg_count)
    );

    // Classify the frame: group addresses arrive in IDLE, lookup results in LOOKUP.
    always_comb begin
        mg_cls   = CLS_FLOOD;
        mg_sport = in_if.src_port_i;
        if (state_q == S_LOOKUP) begin
            mg_sport = sport_q;
            if (lookup_valid_i && lookup_hit_i) begin
                if (lookup_port_i == sport_q)
                    mg_cls = CLS_SELF;
                else if ({1'b0, lookup_port_i} < (PORT_W + 1)'(NUM_PORTS))
                    mg_cls = CLS_UNICAST;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            dest_q   <= '0;
            src_q    <= '0;
            sport_q  <= '0;
            timer_q  <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
            learn_q  <= 1'b0;
            rcv_q    <= 1'b0;
            drop_q   <= 1'b0;
`ifdef FWD_STATS_EN
            st_uni_q <= '0;
            st_fld_q <= '0;
            st_drp_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            dest_q   <= dest_d;
            src_q    <= src_d;
            sport_q  <= sport_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            learn_q  <= learn_d;
            rcv_q    <= rcv_d;
            drop_q   <= drop_d;
`ifdef FWD_STATS_EN
            st_uni_q <= st_uni_d;
            st_fld_q <= st_fld_d;
            st_drp_q <= st_drp_d;
`endif
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        logic inc_uni, inc_fld, inc_drp;
        state_d = state_q;
        ptr_d   = ptr_q;
        dest_d  = dest_q;
        src_d   = src_q;
        sport_d = sport_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        learn_d = 1'b0;
        rcv_d   = 1'b0;
        drop_d  = 1'b0;
        inc_uni = 1'b0;
        inc_fld = 1'b0;
        inc_drp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_if.in_valid_i) begin
                    ptr_d   = in_if.start_ptr_i;
                    dest_d  = in_if.dest_addr_i;
                    src_d   = in_if.src_addr_i;
                    sport_d = in_if.src_port_i;
                    timer_d = '0;
                    learn_d = 1'b1;
                    if (in_if.dest_addr_i[40]) begin
                        state_d = S_DISPATCH;
                        pend_d  = mg_mask;
                        cnt_d   = mg_count;
                        rcv_d   = 1'b1;
                        inc_fld = 1'b1;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                // A response in the final timeout cycle still takes precedence.
                if (lookup_valid_i || timer_q == TMO_W'(LOOKUP_TIMEOUT - 1)) begin
                    rcv_d = 1'b1;
                    if (mg_cls == CLS_SELF) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        drop_d  = 1'b1;
                        inc_drp = 1'b1;
                    end else begin
                        state_d = S_DISPATCH;
                        pend_d  = mg_mask;
                        cnt_d   = mg_count;
                        inc_uni = (mg_cls == CLS_UNICAST);
                        inc_fld = (mg_cls == CLS_FLOOD);
                    end
                end else begin
                    timer_d = timer_q + TMO_W'(1);
                end
            end
            S_DISPATCH: begin
                pend_d = pend_q & ~write_acks_i;
                if (pend_d == '0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FWD_STATS_EN
        st_uni_d = (inc_uni && st_uni_q != '1) ? st_uni_q + 32'd1 : st_uni_q;
        st_fld_d = (inc_fld && st_fld_q != '1) ? st_fld_q + 32'd1 : st_fld_q;
        st_drp_d = (inc_drp && st_drp_q != '1) ? st_drp_q + 32'd1 : st_drp_q;
`else
        if (inc_uni || inc_fld || inc_drp) begin
            drop_d = drop_d;
        end
`endif
    end

    // Output decode from registered state.
    always_comb begin
        in_if.in_ready_o = (state_q == S_IDLE);
        lookup_req_o     = (state_q == S_LOOKUP);
        lookup_addr_o    = dest_q;
        learn_en_o       = learn_q;
        learn_addr_o     = src_q;
        learn_port_o     = sport_q;
        write_reqs_o     = (state_q == S_DISPATCH) ? pend_q : '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            start_ptrs_o[i] = write_reqs_o[i] ? ptr_q : '0;
        end
        refcount_o       = cnt_q;
        refcount_valid_o = rcv_q;
        drop_o           = drop_q;
`ifdef FWD_STATS_EN
        stat_unicast_o   = st_uni_q;
        stat_flood_o     = st_fld_q;
        stat_drop_o      = st_drp_q;
`endif
    end
endmodule

// File: tb/tb_forward_dispatcher.sv
// Scoreboard bench for forward_dispatcher (4 ports, timeout 15).
module tb_forward_dispatcher;
    import fwd_pkg::*;

    typedef struct packed {
        logic [3:0]        reqs;
        logic [2:0]        cnt;
        logic              drop;
        logic [ADDR_W-1:0] ptr;
    } exp_t;

    typedef struct packed {
        logic [47:0] addr;
        logic [1:0]  port;
    } learn_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    lookup_req_o;
    logic [47:0]             lookup_addr_o;
    logic                    lookup_valid_i = 1'b0;
    logic                    lookup_hit_i = 1'b0;
    logic [1:0]              lookup_port_i = '0;
    logic                    learn_en_o;
    logic [47:0]             learn_addr_o;
    logic [1:0]              learn_port_o;
    logic [3:0]              write_reqs_o;
    logic [3:0]              write_acks_i = '0;
    logic [3:0][ADDR_W-1:0]  start_ptrs_o;
    logic [2:0]              refcount_o;
    logic                    refcount_valid_o;
    logic                    drop_o;
`ifdef FWD_STATS_EN
    logic [31:0]             stat_unicast_o, stat_flood_o, stat_drop_o;
`endif

    int total = 0;
    int bad   = 0;
    exp_t   exp_q[$];
    learn_t learn_q[$];

    forward_dispatcher_if #(.NUM_PORTS(4)) in_if ();

    forward_dispatcher #(.NUM_PORTS(4), .LOOKUP_TIMEOUT(15)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_if            (in_if),
        .lookup_req_o     (lookup_req_o),
        .lookup_addr_o    (lookup_addr_o),
        .lookup_valid_i   (lookup_valid_i),
        .lookup_hit_i     (lookup_hit_i),
        .lookup_port_i    (lookup_port_i),
        .learn_en_o       (learn_en_o),
        .learn_addr_o     (learn_addr_o),
        .learn_port_o     (learn_port_o),
        .write_reqs_o     (write_reqs_o),
        .write_acks_i     (write_acks_i),
        .start_ptrs_o     (start_ptrs_o),
        .refcount_o       (refcount_o),
        .refcount_valid_o (refcount_valid_o),
`ifdef FWD_STATS_EN
        .stat_unicast_o   (stat_unicast_o),
        .stat_flood_o     (stat_flood_o),
        .stat_drop_o      (stat_drop_o),
`endif
        .drop_o           (drop_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a result or learn pulse.
    always @(negedge clk) begin
        exp_t   e;
        learn_t l;
        if (!rst) begin
            if (refcount_valid_o) begin
                check("rc_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("refcount", 64'(refcount_o), 64'(e.cnt));
                    check("write_reqs", 64'(write_reqs_o), 64'(e.reqs));
                    check("drop", 64'(drop_o), 64'(e.drop));
                    for (int i = 0; i < 4; i++)
                        if (e.reqs[i]) check("start_ptr", 64'(start_ptrs_o[i]), 64'(e.ptr));
                end
            end else if (drop_o) begin
                check("drop_without_rc", 64'(drop_o), 64'd0);
            end
            if (learn_en_o) begin
                check("learn_expected", 64'(learn_q.size() != 0), 64'd1);
                if (learn_q.size() != 0) begin
                    l = learn_q.pop_front();
                    check("learn_addr", 64'(learn_addr_o), 64'(l.addr));
                    check("learn_port", 64'(learn_port_o), 64'(l.port));
                end
            end
        end
    end

    task automatic send(input logic [47:0] dest, input logic [47:0] src,
                        input logic [1:0] sport, input logic [ADDR_W-1:0] ptr);
        int guard;
        learn_q.push_back('{addr: src, port: sport});
        @(negedge clk);
        in_if.in_valid_i  = 1'b1;
        in_if.dest_addr_i = dest;
        in_if.src_addr_i  = src;
        in_if.src_port_i  = sport;
        in_if.start_ptr_i = ptr;
        guard = 0;
        while (!in_if.in_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", 64'(guard < 50), 64'd1);
        @(posedge clk);
        #1 in_if.in_valid_i = 1'b0;
    endtask

    task automatic lookup_respond(input logic hit, input logic [1:0] port);
        lookup_valid_i = 1'b1;
        lookup_hit_i   = hit;
        lookup_port_i  = port;
        @(posedge clk);
        #1 lookup_valid_i = 1'b0;
        lookup_hit_i = 1'b0;
    endtask

    task automatic ack(input logic [3:0] m);
        write_acks_i = m;
        @(posedge clk);
        #1 write_acks_i = '0;
    endtask

    initial begin
        int n;
        in_if.in_valid_i  = 1'b0;
        in_if.dest_addr_i = '0;
        in_if.src_addr_i  = '0;
        in_if.src_port_i  = '0;
        in_if.start_ptr_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_if.in_ready_o), 64'd1);
        check("rst_write_reqs", 64'(write_reqs_o), 64'd0);
        check("rst_lookup_req", 64'(lookup_req_o), 64'd0);
        check("rst_refcount", 64'(refcount_o), 64'd0);

        // Unicast hit on port 2.
        exp_q.push_back('{reqs: 4'b0100, cnt: 3'd1, drop: 1'b0, ptr: 12'h123});
        send(48'h001122334455, 48'hAABBCCDDEE00, 2'd0, 12'h123);
        @(negedge clk);
        check("uc_lookup_req", 64'(lookup_req_o), 64'd1);
        check("uc_lookup_addr", 64'(lookup_addr_o), 64'h001122334455);
        @(negedge clk);
        check("uc_lookup_hold", 64'(lookup_req_o), 64'd1);
        check("uc_lookup_addr_hold", 64'(lookup_addr_o), 64'h001122334455);
        lookup_respond(1'b1, 2'd2);
        @(negedge clk);
        check("uc_reqs", 64'(write_reqs_o), 64'b0100);
        check("uc_lookup_drop", 64'(lookup_req_o), 64'd0);
        ack(4'b0100);
        @(negedge clk);
        check("uc_idle", 64'(in_if.in_ready_o), 64'd1);

        // Broadcast from port 1: no lookup, dispatch the cycle after accept.
        exp_q.push_back('{reqs: 4'b1101, cnt: 3'd3, drop: 1'b0, ptr: 12'h2AB});
        send(48'hFFFFFFFFFFFF, 48'h020000000001, 2'd1, 12'h2AB);
        @(negedge clk);
        check("bc_no_lookup", 64'(lookup_req_o), 64'd0);
        check("bc_reqs", 64'(write_reqs_o), 64'b1101);
        ack(4'b1101);
        @(negedge clk);
        check("bc_idle", 64'(in_if.in_ready_o), 64'd1);

        // Multicast from port 2; an ack on a non-requested port is ignored.
        exp_q.push_back('{reqs: 4'b1011, cnt: 3'd3, drop: 1'b0, ptr: 12'h0F0});
        send(48'h01005E000001, 48'h020000000002, 2'd2, 12'h0F0);
        @(negedge clk);
        ack(4'b0100);
        @(negedge clk);
        check("mc_stray_ack", 64'(write_reqs_o), 64'b1011);
        ack(4'b1011);
        @(negedge clk);
        check("mc_idle", 64'(in_if.in_ready_o), 64'd1);

        // Hit on own port: drop, zero refcount, immediately ready.
        exp_q.push_back('{reqs: 4'b0000, cnt: 3'd0, drop: 1'b1, ptr: 12'h000});
        send(48'h00AA00BB00CC, 48'h020000000003, 2'd3, 12'h345);
        @(negedge clk);
        lookup_respond(1'b1, 2'd3);
        @(negedge clk);
        check("self_ready", 64'(in_if.in_ready_o), 64'd1);
        check("self_reqs", 64'(write_reqs_o), 64'd0);

        // Lookup timeout: flood after 15 cycles, staggered acks 1,3,2.
        exp_q.push_back('{reqs: 4'b1110, cnt: 3'd3, drop: 1'b0, ptr: 12'h456});
        send(48'h001122334466, 48'h020000000004, 2'd0, 12'h456);
        n = 0;
        @(negedge clk);
        while (write_reqs_o == '0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("tmo_lookup_cycles", 64'(n), 64'd15);
        check("tmo_req_released", 64'(lookup_req_o), 64'd0);
        ack(4'b0010);
        @(negedge clk);
        check("tmo_after_ack1", 64'(write_reqs_o), 64'b1100);
        ack(4'b1000);
        @(negedge clk);
        check("tmo_after_ack3", 64'(write_reqs_o), 64'b0100);
        check("tmo_busy", 64'(in_if.in_ready_o), 64'd0);
        ack(4'b0100);
        @(negedge clk);
        check("tmo_idle", 64'(in_if.in_ready_o), 64'd1);
        check("tmo_reqs_clear", 64'(write_reqs_o), 64'd0);

        // Explicit miss: flood from port 2.
        exp_q.push_back('{reqs: 4'b1011, cnt: 3'd3, drop: 1'b0, ptr: 12'h789});
        send(48'h0A0B0C0D0E0F, 48'h020000000005, 2'd2, 12'h789);
        @(negedge clk);
        lookup_respond(1'b0, 2'd2);
        @(negedge clk);
        check("miss_reqs", 64'(write_reqs_o), 64'b1011);
        ack(4'b1011);
        @(negedge clk);
        check("miss_idle", 64'(in_if.in_ready_o), 64'd1);

        // Reset in DISPATCH with ports 1 and 2 still pending.
        exp_q.push_back('{reqs: 4'b0111, cnt: 3'd3, drop: 1'b0, ptr: 12'hABC});
        send(48'hFFFFFFFFFFFF, 48'h020000000006, 2'd3, 12'hABC);
        @(negedge clk);
        ack(4'b0001);
        @(negedge clk);
        check("rd_pending", 64'(write_reqs_o), 64'b0110);
`ifdef FWD_STATS_EN
        check("stat_unicast", 64'(stat_unicast_o), 64'd1);
        check("stat_flood", 64'(stat_flood_o), 64'd5);
        check("stat_drop", 64'(stat_drop_o), 64'd1);
`endif
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rd_reqs", 64'(write_reqs_o), 64'd0);
        check("rd_in_ready", 64'(in_if.in_ready_o), 64'd1);
        check("rd_ptr2", 64'(start_ptrs_o[2]), 64'd0);
        check("rd_rc_valid", 64'(refcount_valid_o), 64'd0);
        check("rd_refcount", 64'(refcount_o), 64'd0);
        check("rd_learn", 64'(learn_en_o), 64'd0);
        check("rd_drop", 64'(drop_o), 64'd0);
`ifdef FWD_STATS_EN
        check("rd_stat_flood", 64'(stat_flood_o), 64'd0);
        check("rd_stat_unicast", 64'(stat_unicast_o), 64'd0);
        check("rd_stat_drop", 64'(stat_drop_o), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rc_queue_drained", 64'(exp_q.size()), 64'd0);
        check("learn_queue_drained", 64'(learn_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
